// File: rtl/can_rx_msg_fifo.sv
// can_rx_msg_fifo: captures each completed CAN frame, applies the acceptance filter
// (compiled in with CAN_RX_FILTER_EN) and queues accepted frames for valid/ready readout.
module can_rx_msg_fifo #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_done_flag,
    input  logic [10:0]      rx_id_std,
    input  logic [17:0]      rx_id_ext,
    input  logic             rx_ide,
    input  logic [3:0]       rx_dlc,
    input  logic             rx_remote_req,
    input  logic [7:0]       rx_data_array [0:7],
    input  logic [28:0]      acc_code,
    input  logic [28:0]      acc_mask,
    input  logic             rd_ready,
    input  logic             overflow_clr,
    output logic             rd_valid,
    output logic [10:0]      rd_id_std,
    output logic [17:0]      rd_id_ext,
    output logic             rd_ide,
    output logic             rd_rtr,
    output logic [3:0]       rd_dlc,
    output logic [63:0]      rd_data,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_full,
    output logic             overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [10:0] id_std;
        logic [17:0] id_ext;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } entry_t;

    logic             done_q;
    logic             cap_valid_q;
    logic             cap_hit_q;
    entry_t           cap_q;
    entry_t           mem_q [DEPTH];
    entry_t           head_q, head_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;

    logic             event_c;
    logic             hit_c;
    logic [3:0]       dlc_lim_c;
    logic [7:0][7:0]  bytes_c;
    entry_t           frame_c;
    logic             push_c;
    logic             pop_c;
    logic             ovf_set_c;

    assign event_c = rx_done_flag & ~done_q;

    // Frame assembly: bytes beyond min(dlc,8), and all bytes of remote frames, read as zero
    always_comb begin
        dlc_lim_c = (rx_dlc > 4'd8) ? 4'd8 : rx_dlc;
        bytes_c   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!rx_remote_req && (4'(i) < dlc_lim_c)) begin
                bytes_c[3'(7 - i)] = rx_data_array[3'(i)];
            end
        end
        frame_c        = '0;
        frame_c.id_std = rx_id_std;
        frame_c.id_ext = rx_id_ext;
        frame_c.ide    = rx_ide;
        frame_c.rtr    = rx_remote_req;
        frame_c.dlc    = rx_dlc;
        frame_c.data   = bytes_c;
    end

`ifdef CAN_RX_FILTER_EN
    logic [28:0] id29_c;
    logic [28:0] mask_c;

    // Standard frames compare only the 11-bit ID portion of the mask
    always_comb begin
        id29_c = rx_ide ? {rx_id_std, rx_id_ext} : {rx_id_std, 18'b0};
        mask_c = rx_ide ? acc_mask : {acc_mask[28:18], 18'b0};
        hit_c  = ((id29_c ^ acc_code) & mask_c) == 29'b0;
    end
`else
    logic unused_acc_c;

    assign hit_c        = 1'b1;
    assign unused_acc_c = ^{acc_code, acc_mask};
`endif

    // Single-entry capture stage between the frame event and the FIFO write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_hit_q   <= 1'b0;
            cap_q       <= '0;
        end else begin
            done_q      <= rx_done_flag;
            cap_valid_q <= event_c;
            if (event_c) begin
                cap_q     <= frame_c;
                cap_hit_q <= hit_c;
            end
        end
    end

    // FIFO control; the head register bypasses a write that lands in the next head slot
    always_comb begin
        pop_c      = rd_valid_q & rd_ready;
        push_c     = cap_valid_q & cap_hit_q & (~full_q | pop_c);
        ovf_set_c  = cap_valid_q & cap_hit_q & full_q & ~pop_c;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == CNT_W'(DEPTH));
        rd_valid_d = (count_d != '0);
        head_d     = (push_c && (wr_ptr_q == rd_ptr_d)) ? cap_q : mem_q[rd_ptr_d];
        if (ovf_set_c) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= cap_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            head_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            head_q     <= head_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_id_std  = head_q.id_std;
    assign rd_id_ext  = head_q.id_ext;
    assign rd_ide     = head_q.ide;
    assign rd_rtr     = head_q.rtr;
    assign rd_dlc     = head_q.dlc;
    assign rd_data    = head_q.data;
    assign fifo_count = count_q;
    assign fifo_full  = full_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_can_rx_msg_fifo.sv
// Bench for can_rx_msg_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_can_rx_msg_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [10:0]     id_std;
        logic [17:0]     id_ext;
        logic            ide;
        logic            rtr;
        logic [3:0]      dlc;
        logic [7:0][7:0] d;
    } frm_t;

    typedef struct packed {
        logic [10:0] id_std;
        logic [17:0] id_ext;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_done_flag = 1'b0;
    logic [10:0]      rx_id_std = '0;
    logic [17:0]      rx_id_ext = '0;
    logic             rx_ide = 1'b0;
    logic [3:0]       rx_dlc = '0;
    logic             rx_remote_req = 1'b0;
    logic [7:0]       rx_data_array [0:7];
    logic [28:0]      acc_code = '0;
    logic [28:0]      acc_mask = '0;
    logic             rd_ready = 1'b0;
    logic             overflow_clr = 1'b0;
    logic             rd_valid;
    logic [10:0]      rd_id_std;
    logic [17:0]      rd_id_ext;
    logic             rd_ide;
    logic             rd_rtr;
    logic [3:0]       rd_dlc;
    logic [63:0]      rd_data;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int rd_pct   = 50;

    can_rx_msg_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx_done_flag(rx_done_flag),
        .rx_id_std(rx_id_std), .rx_id_ext(rx_id_ext), .rx_ide(rx_ide),
        .rx_dlc(rx_dlc), .rx_remote_req(rx_remote_req), .rx_data_array(rx_data_array),
        .acc_code(acc_code), .acc_mask(acc_mask), .rd_ready(rd_ready),
        .overflow_clr(overflow_clr), .rd_valid(rd_valid), .rd_id_std(rd_id_std),
        .rd_id_ext(rd_id_ext), .rd_ide(rd_ide), .rd_rtr(rd_rtr), .rd_dlc(rd_dlc),
        .rd_data(rd_data), .fifo_count(fifo_count), .fifo_full(fifo_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: what the host should see, derived from the frame rules
    exp_t mq[$];
    bit   m_ovf = 1'b0;
    bit   m_prev = 1'b0;
    bit   m_pend_v = 1'b0;
    bit   m_pend_hit = 1'b0;
    exp_t m_pend = '0;

    function automatic exp_t expect_entry();
        exp_t e;
        int   lim;
        e        = '0;
        e.id_std = rx_id_std;
        e.id_ext = rx_id_ext;
        e.ide    = rx_ide;
        e.rtr    = rx_remote_req;
        e.dlc    = rx_dlc;
        lim      = (int'(rx_dlc) > 8) ? 8 : int'(rx_dlc);
        if (!rx_remote_req) begin
            for (int i = 0; i < lim; i++) begin
                e.data = e.data | (64'(rx_data_array[3'(i)]) << (8 * (7 - i)));
            end
        end
        return e;
    endfunction

    function automatic bit expect_hit();
`ifdef CAN_RX_FILTER_EN
        logic [28:0] id29;
        logic [28:0] m;
        id29 = rx_ide ? {rx_id_std, rx_id_ext} : {rx_id_std, 18'b0};
        m    = rx_ide ? acc_mask : {acc_mask[28:18], 18'b0};
        return ((id29 ^ acc_code) & m) == 29'b0;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0; m_prev = 1'b0; m_pend_v = 1'b0; m_pend_hit = 1'b0;
        end else begin
            bit pop, set;
            pop = (mq.size() != 0) && rd_ready;
            set = 1'b0;
            if (pop) void'(mq.pop_front());
            if (m_pend_v && m_pend_hit) begin
                if (mq.size() < DEPTH) mq.push_back(m_pend);
                else set = 1'b1;
            end
            if (set) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            m_pend_v = rx_done_flag && !m_prev;
            m_prev   = rx_done_flag;
            if (m_pend_v) begin
                m_pend     = expect_entry();
                m_pend_hit = expect_hit();
            end
        end
    end

    always @(negedge clk) begin
        chk("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
        chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
        chk("fifo_full", 64'(fifo_full), 64'(mq.size() == DEPTH));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (mq.size() != 0) begin
            chk("rd_id_std", 64'(rd_id_std), 64'(mq[0].id_std));
            chk("rd_id_ext", 64'(rd_id_ext), 64'(mq[0].id_ext));
            chk("rd_ide", 64'(rd_ide), 64'(mq[0].ide));
            chk("rd_rtr", 64'(rd_rtr), 64'(mq[0].rtr));
            chk("rd_dlc", 64'(rd_dlc), 64'(mq[0].dlc));
            chk("rd_data", rd_data, mq[0].data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rtick();
        rd_ready     = ($urandom_range(0, 99) < rd_pct);
        overflow_clr = ($urandom_range(0, 19) == 0);
        tick(1);
    endtask

    function automatic frm_t mkf(input logic [10:0] s, input logic [17:0] x, input logic ide,
                                 input logic rtr, input logic [3:0] dlc);
        frm_t f;
        f.id_std = s; f.id_ext = x; f.ide = ide; f.rtr = rtr; f.dlc = dlc;
        for (int i = 0; i < 8; i++) f.d[3'(i)] = 8'(8'h11 * (i + 1));
        return f;
    endfunction

    function automatic frm_t rand_frame();
        frm_t f;
        f.id_std = 11'($urandom);
        f.id_ext = 18'($urandom);
        f.ide    = 1'($urandom_range(0, 1));
        f.rtr    = ($urandom_range(0, 4) == 0);
        f.dlc    = 4'($urandom);
        for (int i = 0; i < 8; i++) f.d[3'(i)] = 8'($urandom);
        return f;
    endfunction

    task automatic apply(input frm_t f);
        rx_id_std = f.id_std; rx_id_ext = f.id_ext; rx_ide = f.ide;
        rx_remote_req = f.rtr; rx_dlc = f.dlc;
        for (int i = 0; i < 8; i++) rx_data_array[3'(i)] = f.d[3'(i)];
    endtask

    task automatic send_frame(input frm_t f, input int hold);
        apply(f);
        rx_done_flag = 1'b1;
        tick(hold);
        rx_done_flag = 1'b0;
        tick(1);
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        tick(DEPTH + 2);
        rd_ready = 1'b0;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        frm_t f;
        for (int i = 0; i < 8; i++) rx_data_array[3'(i)] = '0;
        tick(3);
        chk("reset rd_valid", 64'(rd_valid), 64'd0);
        chk("reset fifo_count", 64'(fifo_count), 64'd0);
        chk("reset fifo_full", 64'(fifo_full), 64'd0);
        chk("reset overflow", 64'(overflow), 64'd0);
        chk("reset rd_data", rd_data, 64'd0);
        chk("reset rd_id_std", 64'(rd_id_std), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Long done level yields a single entry with trailing bytes zeroed
        f = mkf(11'h123, 18'h0, 1'b0, 1'b0, 4'd2);
        f.d[0] = 8'hAA; f.d[1] = 8'hBB;
        send_frame(f, 40);
        tick(3);
        chk("t1 fifo_count", 64'(fifo_count), 64'd1);
        chk("t1 rd_data", rd_data, 64'hAABB_0000_0000_0000);
        chk("t1 rd_id_std", 64'(rd_id_std), 64'h123);
        drain();

        // Acceptance filter on the standard ID
        acc_mask = 29'h1FFC0000;
        acc_code = {11'h123, 18'h0};
        send_frame(mkf(11'h123, 18'h0, 1'b0, 1'b0, 4'd1), 1);
        send_frame(mkf(11'h124, 18'h0, 1'b0, 1'b0, 4'd1), 1);
        tick(3);
`ifdef CAN_RX_FILTER_EN
        chk("t2 fifo_count", 64'(fifo_count), 64'd1);
`else
        chk("t2 fifo_count", 64'(fifo_count), 64'd2);
`endif
        chk("t2 head id", 64'(rd_id_std), 64'h123);
        drain();
        acc_mask = '0;

        // Overflow with five frames into four slots, then clear
        for (int k = 0; k < 5; k++) send_frame(mkf(11'(11'h200 + k), 18'h0, 1'b0, 1'b0, 4'd8), 2);
        tick(2);
        chk("t3 fifo_full", 64'(fifo_full), 64'd1);
        chk("t3 overflow", 64'(overflow), 64'd1);
        chk("t3 fifo_count", 64'(fifo_count), 64'd4);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        chk("t3 overflow cleared", 64'(overflow), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t3 order", 64'(rd_id_std), 64'(11'h200 + k));
            rd_ready = 1'b1;
            tick(1);
            rd_ready = 1'b0;
        end
        chk("t3 empty", 64'(fifo_count), 64'd0);

        // Full FIFO with coincident push and pop over three laps
        for (int k = 0; k < 4; k++) send_frame(mkf(11'(11'h10 + k), 18'h0, 1'b0, 1'b0, 4'd0), 1);
        tick(2);
        for (int k = 0; k < 12; k++) begin
            apply(mkf(11'(11'h20 + k), 18'h0, 1'b0, 1'b0, 4'd0));
            rx_done_flag = 1'b1;
            tick(1);
            rx_done_flag = 1'b0;
            rd_ready = 1'b1;
            tick(1);
            rd_ready = 1'b0;
        end
        chk("t4 fifo_count", 64'(fifo_count), 64'd4);
        chk("t4 overflow", 64'(overflow), 64'd0);
        chk("t4 head after laps", 64'(rd_id_std), 64'h28);
        drain();

        // Remote extended frame with stale payload
        f = mkf(11'h7FF, 18'h2ABCD, 1'b1, 1'b1, 4'd8);
        send_frame(f, 3);
        tick(2);
        chk("t5 rd_rtr", 64'(rd_rtr), 64'd1);
        chk("t5 rd_ide", 64'(rd_ide), 64'd1);
        chk("t5 rd_data", rd_data, 64'd0);
        chk("t5 rd_dlc", 64'(rd_dlc), 64'd8);
        drain();

        // Reset between capture and write drops the frame
        apply(mkf(11'h055, 18'h0, 1'b0, 1'b0, 4'd4));
        rx_done_flag = 1'b1;
        tick(1);
        rst_n = 1'b0;
        rx_done_flag = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("t6 fifo_count", 64'(fifo_count), 64'd0);
        chk("t6 rd_valid", 64'(rd_valid), 64'd0);
        send_frame(mkf(11'h066, 18'h0, 1'b0, 1'b0, 4'd4), 1);
        tick(1);
        chk("t6 recapture count", 64'(fifo_count), 64'd1);
        chk("t6 recapture id", 64'(rd_id_std), 64'h066);
        drain();

        // Randomized traffic under varying host read rates
        for (int it = 0; it < 240; it++) begin
            rd_pct = (it < 80) ? 20 : ((it < 160) ? 50 : 90);
            f = rand_frame();
            case ($urandom_range(0, 2))
                0: begin acc_mask = '0; acc_code = 29'($urandom); end
                1: begin
                    acc_mask = 29'($urandom);
                    acc_code = f.ide ? {f.id_std, f.id_ext} : {f.id_std, 18'($urandom)};
                end
                default: begin acc_mask = 29'($urandom); acc_code = 29'($urandom); end
            endcase
            apply(f);
            rx_done_flag = 1'b1;
            repeat ($urandom_range(1, 3)) rtick();
            rx_done_flag = 1'b0;
            repeat ($urandom_range(1, 3)) rtick();
        end
        overflow_clr = 1'b0;
        drain();
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
